alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Upstream command/issue stage for the hierarchical ALU. Accepts one ALU command
//  (operands + 4-bit function) per valid/ready handshake and decodes FUN[3:2] to a
//  one-cycle enable for the arith, logic, cmp or shift unit. Captures the selected
//  unit's registered result/flag and returns it on a valid/ready result port.
//  Only one command is in flight at a time.
// PARAMETERS
//  WIDTH    16  operand width; arith_out is 2*WIDTH, all other unit outputs are WIDTH
//  TIMEOUT  4   max WAIT cycles for the selected unit flag before error (>=1)
// PORTS
//  clk         in   1        single clock, rising edge
//  reset       in   1        synchronous, active-high reset
//  cmd_valid   in   1        command present
//  cmd_ready   out  1        block can accept (high only in IDLE)
//  cmd_a       in   WIDTH    operand A
//  cmd_b       in   WIDTH    operand B
//  cmd_fun     in   4        [3:2] unit sel (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] op
//  A, B        out  WIDTH    registered operands driven to all units
//  ALU_FUN     out  2        registered cmd_fun[1:0] driven to all units
//  arith_en    out  1        one-hot unit enables, registered
//  logic_en    out  1
//  cmp_en      out  1
//  shift_en    out  1
//  arith_out   in   2*WIDTH  unit results (registered inside each unit)
//  logic_out   in   WIDTH
//  cmp_out     in   WIDTH
//  shift_out   in   WIDTH
//  arith_flag  in   1        unit result-valid flags
//  logic_flag  in   1
//  cmp_flag    in   1
//  shift_flag  in   1
//  res_valid   out  1        result held valid until res_ready
//  res_ready   in   1        downstream accepts result
//  res_data    out  2*WIDTH  captured result; WIDTH-wide results zero-extended
//  res_unit    out  2        unit that produced res_data (= cmd_fun[3:2])
//  res_err     out  1        1 = selected flag not seen within TIMEOUT; res_data = 0
//  busy        out  1        high whenever state != IDLE
// BEHAVIOUR
//  - Reset (sync, high): state IDLE; all outputs 0 except cmd_ready = 1 in the cycle after reset
//    deasserts. Reset mid-command discards the command; no result is produced.
//  - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered.
//  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready: latch A, B, ALU_FUN, and the unit select; -> ISSUE.
//  - ISSUE: exactly one enable high for exactly this cycle; wait counter cleared; -> WAIT.
//  - WAIT: all enables 0. A/B/ALU_FUN hold their values. Only the selected unit's flag and
//    output are sampled; flags of other units are ignored.
//      selected flag=1 -> res_data <= output (zero-extended), res_err<=0; -> RESP.
//      else counter++; counter==TIMEOUT-1 with no flag -> res_data<=0, res_err<=1; -> RESP.
//  - Nominal latency: accept edge to res_valid = 3 cycles (ISSUE, 1 WAIT, RESP).
//  - RESP: res_valid=1; res_data/res_unit/res_err stable until res_valid&res_ready -> IDLE
//    (res_valid drops the next cycle). cmd_ready stays 0 in RESP; there is no accept-on-retire.
//  - A/B/ALU_FUN keep their last values in IDLE. Units deassert their flags when en is low.
// STRUCTURE
//  - alu_pkg: unit-select localparams (UNIT_ARITH..UNIT_SHIFT), FSM state encoding, TIMEOUT default.
//  - One sub-module, alu_unit_decode: combinational FUN[3:2] -> one-hot enable vector plus
//    result/flag select mux. FSM, counter and registers live in the top level.
// TESTING
//  - Logic AND: a=16'h00F0 b=16'h0FF0 fun=4'b0100 -> logic_en high 1 cycle; res_data=32'h00F0, unit=01, err=0, 3-cycle latency.
//  - Arith mult: a=16'h0100 b=16'h0100 fun=4'b0010 -> arith_en only; res_data=32'h0001_0000.
//  - Backpressure: res_ready=0 for 5 cycles -> res_valid, res_data stable; cmd_ready=0; second cmd_valid not accepted.
//  - Timeout: stub cmp_flag tied 0, fun=4'b1000 -> after TIMEOUT WAIT cycles res_err=1, res_data=0.
//  - Foreign flag: shift selected, logic_flag forced 1 in WAIT -> ignored; shift_out captured.
//  - Reset in WAIT: reset=1 one cycle -> state IDLE, enables 0, no res_valid; cmd_ready=1 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: unit select codes, FSM states,
// default parameters and the unit-select to one-hot enable helper.
package alu_pkg;

    // Unit select codes carried in cmd_fun[3:2].
    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    localparam int WIDTH_DEFAULT   = 16;
    localparam int TIMEOUT_DEFAULT = 4;

    // One command in flight: accept, pulse the enable, wait for the flag, hand back.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Bit n of the result is the enable for unit code n.
    function automatic logic [3:0] unit_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/alu_unit_decode.sv
// Combinational unit decode: turns a unit select into the one-hot enable
// vector and picks the selected unit's result and flag out of the four units.
module alu_unit_decode
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [1:0]         i_en_sel,
    input  logic [1:0]         i_mux_sel,
    input  logic [2*WIDTH-1:0] i_arith_out,
    input  logic [WIDTH-1:0]   i_logic_out,
    input  logic [WIDTH-1:0]   i_cmp_out,
    input  logic [WIDTH-1:0]   i_shift_out,
    input  logic               i_arith_flag,
    input  logic               i_logic_flag,
    input  logic               i_cmp_flag,
    input  logic               i_shift_flag,
    output logic [3:0]         o_en_onehot,
    output logic [2*WIDTH-1:0] o_sel_data,
    output logic               o_sel_flag
);

    // Enable vector for the incoming command's unit.
    always_comb begin
        o_en_onehot = unit_onehot(i_en_sel);
    end

    // Only the latched unit's result and flag reach the FSM; other flags are ignored.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        o_sel_data = '0;
        o_sel_flag = 1'b0;
        case (i_mux_sel)
            UNIT_ARITH: begin
                o_sel_data = i_arith_out;
                o_sel_flag = i_arith_flag;
            end
            UNIT_LOGIC: begin
                o_sel_data = {{WIDTH{1'b0}}, i_logic_out};
                o_sel_flag = i_logic_flag;
            end
            UNIT_CMP: begin
                o_sel_data = {{WIDTH{1'b0}}, i_cmp_out};
                o_sel_flag = i_cmp_flag;
            end
            UNIT_SHIFT: begin
                o_sel_data = {{WIDTH{1'b0}}, i_shift_out};
                o_sel_flag = i_shift_flag;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU command/issue stage: accepts one command, pulses the selected unit's
// enable for one cycle, waits (bounded) for that unit's flag and presents the
// captured result on a valid/ready response port. All outputs are registered.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [3:0]         cmd_fun,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    output logic [1:0]         ALU_FUN,
    output logic               arith_en,
    output logic               logic_en,
    output logic               cmp_en,
    output logic               shift_en,
    input  logic [2*WIDTH-1:0] arith_out,
    input  logic [WIDTH-1:0]   logic_out,
    input  logic [WIDTH-1:0]   cmp_out,
    input  logic [WIDTH-1:0]   shift_out,
    input  logic               arith_flag,
    input  logic               logic_flag,
    input  logic               cmp_flag,
    input  logic               shift_flag,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_data,
    output logic [1:0]         res_unit,
    output logic               res_err,
    output logic               busy
);

    // Wait counter counts 0..TIMEOUT-1; at least one bit even for TIMEOUT == 1.
    localparam int          CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_timeout;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [1:0]           r_fun;
    logic [1:0]           r_unit;
    logic [3:0]           r_en;
    logic                 r_cmd_ready;
    logic                 r_busy;
    logic                 r_res_valid;
    logic [2*WIDTH-1:0]   r_res_data;
    logic [1:0]           r_res_unit;
    logic                 r_res_err;

    logic [3:0]           w_en_onehot;
    logic [2*WIDTH-1:0]   w_sel_data;
    logic                 w_sel_flag;

    // Enable decode from the incoming command; result/flag mux from the latched unit.
    alu_unit_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .i_en_sel     (cmd_fun[3:2]),
        .i_mux_sel    (r_unit),
        .i_arith_out  (arith_out),
        .i_logic_out  (logic_out),
        .i_cmp_out    (cmp_out),
        .i_shift_out  (shift_out),
        .i_arith_flag (arith_flag),
        .i_logic_flag (logic_flag),
        .i_cmp_flag   (cmp_flag),
        .i_shift_flag (shift_flag),
        .o_en_onehot  (w_en_onehot),
        .o_sel_data   (w_sel_data),
        .o_sel_flag   (w_sel_flag)
    );

    // Handshake uses the state directly; cmd_ready mirrors it one-for-one.
    assign w_accept = (r_state == ST_IDLE) && cmd_valid;

    // Next-state, wait counter and capture/timeout decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A flag in the last allowed cycle still counts as success.
                if (w_sel_flag) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_RESP: begin
                // No accept-on-retire: IDLE must be visited before the next command.
                if (res_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, command registers, enables and response registers; outputs follow next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_fun       <= '0;
            r_unit      <= '0;
            r_en        <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_unit  <= '0;
            r_res_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_res_valid <= (w_state_nxt == ST_RESP);
            r_en        <= w_accept ? w_en_onehot : 4'b0000;
            if (w_accept) begin
                r_a    <= cmd_a;
                r_b    <= cmd_b;
                r_fun  <= cmd_fun[1:0];
                r_unit <= cmd_fun[3:2];
            end
            if (w_capture) begin
                r_res_data <= w_sel_data;
                r_res_err  <= 1'b0;
                r_res_unit <= r_unit;
            end else if (w_timeout) begin
                r_res_data <= '0;
                r_res_err  <= 1'b1;
                r_res_unit <= r_unit;
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign A         = r_a;
    assign B         = r_b;
    assign ALU_FUN   = r_fun;
    assign arith_en  = r_en[0];
    assign logic_en  = r_en[1];
    assign cmp_en    = r_en[2];
    assign shift_en  = r_en[3];
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_unit  = r_res_unit;
    assign res_err   = r_res_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU unit stubs, a table
// of directed commands with hand-computed results, and hand-written sequences
// for backpressure, timeout, foreign flag and reset during WAIT.
module tb_alu_issue_ctrl;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic [3:0]    cmd_fun;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [1:0]    ALU_FUN;
    logic          arith_en, logic_en, cmp_en, shift_en;
    logic [2*W-1:0] arith_out;
    logic [W-1:0]  logic_out, cmp_out, shift_out;
    logic          arith_flag, logic_flag, cmp_flag, shift_flag;
    logic          res_valid;
    logic          res_ready;
    logic [2*W-1:0] res_data;
    logic [1:0]    res_unit;
    logic          res_err;
    logic          busy;

    // Stub controls
    logic          kill_cmp;      // cmp unit never raises its flag
    logic          force_logic;   // logic_flag stuck high
    logic          shift_slow;    // shift flag arrives one cycle later

    logic          arith_flag_r, logic_flag_r, cmp_flag_r, shift_flag_r, sh_d1;
    logic [3:0]    en_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(W), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_fun    (cmd_fun),
        .A          (A),
        .B          (B),
        .ALU_FUN    (ALU_FUN),
        .arith_en   (arith_en),
        .logic_en   (logic_en),
        .cmp_en     (cmp_en),
        .shift_en   (shift_en),
        .arith_out  (arith_out),
        .logic_out  (logic_out),
        .cmp_out    (cmp_out),
        .shift_out  (shift_out),
        .arith_flag (arith_flag),
        .logic_flag (logic_flag),
        .cmp_flag   (cmp_flag),
        .shift_flag (shift_flag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_unit   (res_unit),
        .res_err    (res_err),
        .busy       (busy)
    );

    assign en_vec     = {shift_en, cmp_en, logic_en, arith_en};
    assign arith_flag = arith_flag_r;
    assign logic_flag = logic_flag_r | force_logic;
    assign cmp_flag   = cmp_flag_r & ~kill_cmp;
    assign shift_flag = shift_flag_r;

    // Unit stubs: result registered on enable, flag high the cycle after enable.
    always @(posedge clk) begin
        if (reset) begin
            arith_flag_r <= 1'b0;
            logic_flag_r <= 1'b0;
            cmp_flag_r   <= 1'b0;
            shift_flag_r <= 1'b0;
            sh_d1        <= 1'b0;
            arith_out    <= '0;
            logic_out    <= '0;
            cmp_out      <= '0;
            shift_out    <= '0;
        end else begin
            arith_flag_r <= arith_en;
            logic_flag_r <= logic_en;
            cmp_flag_r   <= cmp_en;
            sh_d1        <= shift_en;
            shift_flag_r <= shift_slow ? sh_d1 : shift_en;
            if (arith_en) begin
                case (ALU_FUN)
                    2'd0: arith_out <= {16'h0, A} + {16'h0, B};
                    2'd1: arith_out <= {16'h0, A} - {16'h0, B};
                    2'd2: arith_out <= {16'h0, A} * {16'h0, B};
                    default: arith_out <= {16'h0, A};
                endcase
            end
            if (logic_en) begin
                case (ALU_FUN)
                    2'd0: logic_out <= A & B;
                    2'd1: logic_out <= A | B;
                    2'd2: logic_out <= A ^ B;
                    default: logic_out <= ~A;
                endcase
            end
            if (cmp_en) begin
                case (ALU_FUN)
                    2'd0: cmp_out <= (A == B) ? 16'd1 : 16'd0;
                    2'd1: cmp_out <= (A < B) ? 16'd1 : 16'd0;
                    2'd2: cmp_out <= (A > B) ? 16'd1 : 16'd0;
                    default: cmp_out <= 16'd0;
                endcase
            end
            if (shift_en) begin
                case (ALU_FUN)
                    2'd0: shift_out <= A << B[3:0];
                    2'd1: shift_out <= A >> B[3:0];
                    default: shift_out <= A;
                endcase
            end
        end
    end

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [3:0]     fun;
        logic [2*W-1:0] exp_data;
        logic [1:0]     exp_unit;
        logic [3:0]     exp_en;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts and ends at a negedge; returns in the ISSUE cycle.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] fun);
        check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd_a     = a;
        cmd_b     = b;
        cmd_fun   = fun;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Counts cycles from the ISSUE cycle (=1) to the first cycle with res_valid.
    task automatic wait_res(output int lat, output logic [3:0] en_or, output int en_cycles);
        lat = 1;
        en_or = 4'b0;
        en_cycles = 0;
        while (!res_valid && lat < 20) begin
            en_or = en_or | en_vec;
            if (en_vec != 4'b0) en_cycles++;
            @(negedge clk);
            lat++;
        end
        check("res_valid_seen", {31'b0, res_valid}, 32'd1);
    endtask

    task automatic retire();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_drop", {31'b0, res_valid}, 32'd0);
        check("cmd_ready_after_retire", {31'b0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int         lat;
        int         en_cycles;
        logic [3:0] en_or;
        logic       rv_seen;

        //        a         b         fun      exp_data         unit   en
        vecs[0]  = '{16'h00F0, 16'h0FF0, 4'b0100, 32'h0000_00F0, 2'd1, 4'b0010}; // AND
        vecs[1]  = '{16'h0100, 16'h0100, 4'b0010, 32'h0001_0000, 2'd0, 4'b0001}; // MUL
        vecs[2]  = '{16'hFFFF, 16'h0001, 4'b0000, 32'h0001_0000, 2'd0, 4'b0001}; // ADD carry
        vecs[3]  = '{16'h0003, 16'h0005, 4'b0001, 32'hFFFF_FFFE, 2'd0, 4'b0001}; // SUB
        vecs[4]  = '{16'hFFFF, 16'hFFFF, 4'b0010, 32'hFFFE_0001, 2'd0, 4'b0001}; // MUL max
        vecs[5]  = '{16'h1234, 16'h00FF, 4'b0101, 32'h0000_12FF, 2'd1, 4'b0010}; // OR
        vecs[6]  = '{16'h1234, 16'h00FF, 4'b0110, 32'h0000_12CB, 2'd1, 4'b0010}; // XOR
        vecs[7]  = '{16'h0005, 16'h0005, 4'b1000, 32'h0000_0001, 2'd2, 4'b0100}; // EQ
        vecs[8]  = '{16'h0003, 16'h0009, 4'b1001, 32'h0000_0001, 2'd2, 4'b0100}; // LT
        vecs[9]  = '{16'h8001, 16'h0004, 4'b1100, 32'h0000_0010, 2'd3, 4'b1000}; // SHL
        vecs[10] = '{16'h8001, 16'h0004, 4'b1101, 32'h0000_0800, 2'd3, 4'b1000}; // SHR

        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_fun     = '0;
        res_ready   = 1'b0;
        kill_cmp    = 1'b0;
        force_logic = 1'b0;
        shift_slow  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_enables", {28'b0, en_vec}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_A", {16'b0, A}, 32'd0);
        @(negedge clk);
        check("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // Table-driven commands
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].fun);
            check("busy_issue", {31'b0, busy}, 32'd1);
            check("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
            wait_res(lat, en_or, en_cycles);
            check("latency", lat, 32'd3);
            check("en_onehot", {28'b0, en_or}, {28'b0, vecs[i].exp_en});
            check("en_cycles", en_cycles, 32'd1);
            check("res_data", res_data, vecs[i].exp_data);
            check("res_unit", {30'b0, res_unit}, {30'b0, vecs[i].exp_unit});
            check("res_err", {31'b0, res_err}, 32'd0);
            check("A_hold", {16'b0, A}, {16'b0, vecs[i].a});
            check("B_hold", {16'b0, B}, {16'b0, vecs[i].b});
            check("ALU_FUN_hold", {30'b0, ALU_FUN}, {30'b0, vecs[i].fun[1:0]});
            retire();
        end

        // Backpressure: result held, second command refused
        issue(16'hFF00, 16'h0F0F, 4'b0100);
        wait_res(lat, en_or, en_cycles);
        check("bp_latency", lat, 32'd3);
        cmd_a     = 16'h1111;
        cmd_b     = 16'h2222;
        cmd_fun   = 4'b0000;
        cmd_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_res_valid", {31'b0, res_valid}, 32'd1);
            check("bp_res_data", res_data, 32'h0000_0F00);
            check("bp_res_unit", {30'b0, res_unit}, 32'd1);
            check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            check("bp_enables", {28'b0, en_vec}, 32'd0);
        end
        cmd_valid = 1'b0;
        check("bp_A_kept", {16'b0, A}, 32'h0000_FF00);
        retire();
        check("bp_no_second_accept", {31'b0, busy}, 32'd0);
        check("bp_A_after", {16'b0, A}, 32'h0000_FF00);

        // Timeout: cmp flag never arrives
        kill_cmp = 1'b1;
        issue(16'h0005, 16'h0005, 4'b1000);
        wait_res(lat, en_or, en_cycles);
        check("to_latency", lat, 32'd6);
        check("to_res_err", {31'b0, res_err}, 32'd1);
        check("to_res_data", res_data, 32'd0);
        check("to_res_unit", {30'b0, res_unit}, 32'd2);
        retire();
        kill_cmp = 1'b0;

        // Foreign flag: logic_flag high while shift is selected and late
        force_logic = 1'b1;
        shift_slow  = 1'b1;
        issue(16'h00F1, 16'h0001, 4'b1100);
        wait_res(lat, en_or, en_cycles);
        check("ff_latency", lat, 32'd4);
        check("ff_res_data", res_data, 32'h0000_01E2);
        check("ff_res_unit", {30'b0, res_unit}, 32'd3);
        check("ff_res_err", {31'b0, res_err}, 32'd0);
        check("ff_en", {28'b0, en_or}, 32'h8);
        retire();
        force_logic = 1'b0;
        shift_slow  = 1'b0;

        // Reset during WAIT discards the command
        kill_cmp = 1'b1;
        issue(16'h0001, 16'h0002, 4'b1001);
        @(negedge clk);
        check("rw_in_wait_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rw_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rw_busy", {31'b0, busy}, 32'd0);
        check("rw_enables", {28'b0, en_vec}, 32'd0);
        check("rw_res_valid", {31'b0, res_valid}, 32'd0);
        rv_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            rv_seen = rv_seen | res_valid;
        end
        check("rw_no_result", {31'b0, rv_seen}, 32'd0);
        check("rw_idle_ready", {31'b0, cmd_ready}, 32'd1);
        kill_cmp = 1'b0;

        // Normal operation resumes after the mid-command reset
        issue(16'h0009, 16'h0003, 4'b1010);
        wait_res(lat, en_or, en_cycles);
        check("post_rst_latency", lat, 32'd3);
        check("post_rst_data", res_data, 32'd1);
        retire();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
